// File: rtl/microwave_timer_sequencer.sv
// Cook-timer sequencer: keypad digit entry, M:SS BCD countdown on 1 Hz ticks, magnetron/beep control.
// Optional `QUICK_START_EN: start in IDLE with the door closed loads 0:30 and begins cooking.
module microwave_timer_sequencer #(
  parameter int unsigned DONE_TICKS  = 3,
  parameter bit          START_LEVEL = 1'b0
) (
  input  logic       clock_100Hz,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       load_n,
  input  logic       pgt_1Hz,
  input  logic       start_n,
  input  logic       stop_n,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       mag_on,
  output logic       beep,
  output logic       keypad_enable_n,
  output logic       zero
);

  typedef enum logic [2:0] {IDLE, SET, COOK, PAUSE, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] ones_next, tens_next, mins_next;
  logic [3:0] done_cnt, done_cnt_next;
  logic [4:0] done_inc;
  logic       load_n_d, start_n_d, stop_n_d;
  logic       tick_s1, tick_s2, tick_s3;
  logic       dig_evt, start_evt, stop_evt, tick_evt, digit_ok, shift_nonzero;
  logic [3:0] dec_ones, dec_tens, dec_mins;
  logic       dec_zero;

  // Buttons fire once on the transition into their active level, so a held key is a single event.
  assign dig_evt   = load_n_d & ~load_n;
  assign start_evt = (start_n_d != START_LEVEL) && (start_n == START_LEVEL);
  assign stop_evt  = (stop_n_d != START_LEVEL) && (stop_n == START_LEVEL);
  assign tick_evt  = tick_s2 & ~tick_s3;

  assign digit_ok      = (D <= 4'd9);
  assign shift_nonzero = |{sec_tens, sec_ones, D};
  assign done_inc      = {1'b0, done_cnt} + 5'd1;

  // One-second borrow chain; seconds tens wrap to 5 so entries like 0:99 still count down.
  always_comb begin
    dec_ones = sec_ones - 4'd1;
    dec_tens = sec_tens;
    dec_mins = min_ones;
    if (sec_ones == 4'd0) begin
      dec_ones = 4'd9;
      if (sec_tens == 4'd0) begin
        dec_tens = 4'd5;
        dec_mins = min_ones - 4'd1;
      end else begin
        dec_tens = sec_tens - 4'd1;
      end
    end
    dec_zero = ~|{dec_mins, dec_tens, dec_ones};
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_100Hz or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      sec_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      min_ones  <= 4'd0;
      done_cnt  <= 4'd0;
      load_n_d  <= 1'b0;
      start_n_d <= 1'b0;
      stop_n_d  <= 1'b0;
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_s3   <= 1'b0;
    end else begin
      state     <= state_next;
      sec_ones  <= ones_next;
      sec_tens  <= tens_next;
      min_ones  <= mins_next;
      done_cnt  <= done_cnt_next;
      load_n_d  <= load_n;
      start_n_d <= start_n;
      stop_n_d  <= stop_n;
      tick_s1   <= pgt_1Hz;
      tick_s2   <= tick_s1;
      tick_s3   <= tick_s2;
    end
  end

  // Branch order in each state encodes priority: stop > door open > start > tick > digit.
  always_comb begin
    // NOTE: every output of this block gets a hold default first so no path can infer a latch.
    state_next    = state;
    ones_next     = sec_ones;
    tens_next     = sec_tens;
    mins_next     = min_ones;
    done_cnt_next = done_cnt;
    unique case (state)
      IDLE: begin
        if (stop_evt) begin
          state_next = IDLE;
        end
`ifdef QUICK_START_EN
        else if (start_evt && door_closed) begin
          ones_next  = 4'd0;
          tens_next  = 4'd3;
          mins_next  = 4'd0;
          state_next = COOK;
        end
`endif
        else if (dig_evt && digit_ok) begin
          mins_next = sec_tens;
          tens_next = sec_ones;
          ones_next = D;
          if (shift_nonzero) state_next = SET;
        end
      end
      SET: begin
        if (stop_evt) begin
          ones_next  = 4'd0;
          tens_next  = 4'd0;
          mins_next  = 4'd0;
          state_next = IDLE;
        end else if (start_evt && door_closed) begin
          state_next = COOK;
        end else if (dig_evt && digit_ok) begin
          mins_next = sec_tens;
          tens_next = sec_ones;
          ones_next = D;
        end
      end
      COOK: begin
        if (stop_evt || !door_closed) begin
          state_next = PAUSE;
        end else if (tick_evt) begin
          if (zero) begin
            state_next = DONE;
          end else begin
            ones_next = dec_ones;
            tens_next = dec_tens;
            mins_next = dec_mins;
            if (dec_zero) state_next = DONE;
          end
        end
      end
      PAUSE: begin
        if (stop_evt) begin
          ones_next  = 4'd0;
          tens_next  = 4'd0;
          mins_next  = 4'd0;
          state_next = IDLE;
        end else if (start_evt && door_closed) begin
          state_next = COOK;
        end
      end
      DONE: begin
        if (stop_evt || !door_closed) begin
          state_next = IDLE;
        end else if (tick_evt) begin
          if (done_inc >= 5'(DONE_TICKS)) state_next = IDLE;
          else                            done_cnt_next = done_inc[3:0];
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next != DONE) done_cnt_next = 4'd0;
  end

  // Outputs decode straight from state so an asynchronous clear drops mag_on immediately.
  always_comb begin
    mag_on          = (state == COOK);
    beep            = (state == DONE);
    keypad_enable_n = !((state == IDLE) || (state == SET));
    zero            = ~|{min_ones, sec_tens, sec_ones};
  end

endmodule

// File: doc/microwave_timer_sequencer.md
Name: microwave_timer_sequencer

Overview:
- Sequences the cook timer of the microwave controller.
- Consumes the keypad digit stream (D/load_n) and the 1 Hz pulse train from the timer input control block.
- Holds a 3-digit BCD cook time (M:SS), counts it down while cooking, and drives magnetron enable, done/beep indication and the keypad enable.
- Sits between timer input control and the display/magnetron drivers.

Parameters:
- DONE_TICKS, 3: number of 1 Hz ticks that beep stays high in DONE before returning to IDLE; range 1..15.
- START_LEVEL, 0: active level of start_n and stop_n; 0 means active-low.

Ports:
- clock_100Hz  input  1  system clock; all logic is on the rising edge.
- clear  input  1  asynchronous, active-high reset.
- D  input  4  BCD digit from the keypad encoder; valid while load_n is low.
- load_n  input  1  active-low digit strobe, synchronous to clock_100Hz; held low for the whole key press.
- pgt_1Hz  input  1  1 Hz square wave; each rising edge is one tick.
- start_n  input  1  start button, active-low, synchronous.
- stop_n  input  1  stop/clear button, active-low, synchronous.
- door_closed  input  1  1 = door closed.
- sec_ones  output  4  BCD seconds units.
- sec_tens  output  4  BCD seconds tens (0..9 allowed at entry).
- min_ones  output  4  BCD minutes.
- mag_on  output  1  magnetron enable; high only in COOK.
- beep  output  1  high in DONE.
- keypad_enable_n  output  1  low when digit entry is accepted (IDLE, SET).
- zero  output  1  high when all three digits are 0.

Behaviour:
- Clock and reset: one clock (clock_100Hz). clear is asynchronous and active-high.
- Reset values: state=IDLE, all digits 0, mag_on=0, beep=0, keypad_enable_n=0, zero=1, done counter 0, all edge registers 0. A reset mid-cook drops mag_on on the asynchronous assertion of clear.
- Events:
  - dig_evt: load_n was 1 on the previous cycle and is 0 now; D is sampled on that cycle.
  - start_evt and stop_evt: same 1→0 detection on start_n and stop_n.
  - tick_evt: pgt_1Hz passes through a 2-flop synchronizer; tick_evt is high for 1 cycle when the synchronized value goes 0→1.
  - Holding a button produces exactly one event.
- Digit entry (IDLE or SET only):
  - On dig_evt with D≤9: min_ones←sec_tens, sec_tens←sec_ones, sec_ones←D. The old min_ones digit is discarded.
  - D>9 is ignored.
  - Digits change on the same edge the event is detected.
- Countdown, on tick_evt in COOK:
  - sec_ones decrements.
  - At 0 it wraps to 9 and borrows from sec_tens.
  - sec_tens at 0 wraps to 5 and borrows from min_ones.
  - Entered values such as 0:99 count down correctly: 0:99→0:98…0:90→0:89.
- State machine:
  - IDLE: dig_evt yielding a nonzero time → SET; otherwise stay IDLE.
  - SET: stop_evt → clear digits, IDLE. start_evt with door_closed=1 → COOK. start_evt with the door open is ignored.
  - COOK: stop_evt or door_closed=0 → PAUSE, mag_on falls on the next edge. tick_evt that makes the digits 0:00 → DONE on that same edge; mag_on is low from the next cycle.
  - PAUSE: digits frozen, dig_evt ignored, ticks ignored. start_evt with door_closed=1 → COOK. stop_evt → clear digits, IDLE.
  - DONE: beep=1; the done counter increments per tick_evt. After DONE_TICKS ticks → IDLE with the counter cleared. stop_evt or door_closed=0 → IDLE immediately.
- Same-cycle priority: stop_evt > door open > start_evt > tick_evt > dig_evt.
- zero is combinational from the digits.

Optional Feature:
- QUICK_START_EN defined: start_evt in IDLE with door_closed=1 loads 0:30 and enters COOK on the same edge.
- Not defined: start_evt in IDLE is ignored.

Test Plan:
- Reset and entry: keys 1, 3, 0 → digits 1:30, state SET, keypad_enable_n=0. A fourth key 5 → 3:05.
- Countdown borrow: load 1:00, start with door closed, 1 tick → 0:59 with mag_on=1. Load 0:99, 1 tick → 0:98.
- Finish: load 0:02, start, 2 ticks → 0:00, beep=1, mag_on=0. After 3 more ticks → IDLE, beep=0.
- Pause/resume: cooking at 0:45, open door → mag_on=0 and digits hold across 5 ticks. Close door and start → resumes at 0:45. stop_evt in PAUSE → 0:00, IDLE.
- Edge and priority cases:
  - Key held for 50 cycles → exactly one shift.
  - D=12 ignored.
  - start and stop in the same cycle in SET → IDLE.
  - clear asserted mid-cook → all outputs at reset values immediately.
- QUICK_START_EN: start in IDLE → 0:30 and COOK. Without the macro → stays IDLE.
